// File: rtl/rvh_l1d_credit_tracker.sv
// Population count of a request/release mask.
// Latency: combinational.
// Backpressure: none; pure reduction.
module one_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

endmodule

// Multi-lane free-entry credit tracker with a flush/drain sequencer.
// Latency: grants come from registered state; released credit is grantable 1 cycle later.
// Backpressure: per-lane alloc_rdy_o is a low-lane prefix of free credit, forced low while draining.
module rvh_l1d_credit_tracker #(
    parameter int ENTRY_NUM   = 8,
    parameter int ALLOC_WIDTH = 2,
    parameter int REL_WIDTH   = 4,
    localparam int CNT_W      = $clog2(ENTRY_NUM) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALLOC_WIDTH-1:0] alloc_vld_i,
    output logic [ALLOC_WIDTH-1:0] alloc_rdy_o,
    input  logic [REL_WIDTH-1:0]   rel_vld_i,
    input  logic                   flush_req_i,
    output logic                   flush_done_o,
    output logic [CNT_W-1:0]       free_cnt_o,
    output logic [CNT_W-1:0]       used_cnt_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int A_CW  = $clog2(ALLOC_WIDTH + 1);
    localparam int R_CW  = $clog2(REL_WIDTH + 1);
    // One guard bit above the wider operand so an over-release never wraps.
    localparam int SUM_W = ((CNT_W > R_CW) ? CNT_W : R_CW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       free_cnt_q;
    logic [CNT_W-1:0]       free_next;
    logic                   err_q;
    logic [ALLOC_WIDTH-1:0] fire;
    logic [A_CW-1:0]        n_alloc;
    logic [R_CW-1:0]        n_rel;
    logic [SUM_W-1:0]       free_sum;
    logic                   over_rel;

    always_comb begin
        alloc_rdy_o = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_rdy_o[i] = (state_q == IDLE) && (CNT_W'(i) < free_cnt_q);
        end
    end

    assign fire = alloc_vld_i & alloc_rdy_o;

    one_counter #(.WIDTH(ALLOC_WIDTH), .CNT_W(A_CW)) u_alloc_cnt (
        .vec (fire),
        .cnt (n_alloc)
    );

    one_counter #(.WIDTH(REL_WIDTH), .CNT_W(R_CW)) u_rel_cnt (
        .vec (rel_vld_i),
        .cnt (n_rel)
    );

    // n_alloc never exceeds free_cnt_q because grants are capped by it.
    assign free_sum  = SUM_W'(free_cnt_q) + SUM_W'(n_rel) - SUM_W'(n_alloc);
    assign over_rel  = free_sum > SUM_W'(ENTRY_NUM);
    assign free_next = over_rel ? CNT_W'(ENTRY_NUM) : free_sum[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_req_i) state_d = DRAIN;
            DRAIN:   if (free_cnt_q == CNT_W'(ENTRY_NUM)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            free_cnt_q <= CNT_W'(ENTRY_NUM);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            free_cnt_q <= free_next;
            if (over_rel) begin
                err_q <= 1'b1;
            end
        end
    end

    assign flush_done_o = (state_q == DONE);
    assign free_cnt_o   = free_cnt_q;
    assign used_cnt_o   = CNT_W'(ENTRY_NUM) - free_cnt_q;
    assign full_o       = (free_cnt_q == '0);
    assign empty_o      = (free_cnt_q == CNT_W'(ENTRY_NUM));
    assign err_o        = err_q;

endmodule

// File: tb/tb_rvh_l1d_credit_tracker.sv
// Bench for rvh_l1d_credit_tracker: directed vector table, reset-mid-drain sequence,
// then random traffic against a credit/flush reference model.
module tb_rvh_l1d_credit_tracker;

    localparam int E  = 8;
    localparam int AW = 2;
    localparam int RW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] alloc_vld;
    logic [AW-1:0] alloc_rdy;
    logic [RW-1:0] rel_vld;
    logic          flush_req;
    logic          flush_done;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] used_cnt;
    logic          full;
    logic          empty;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rvh_l1d_credit_tracker #(.ENTRY_NUM(E), .ALLOC_WIDTH(AW), .REL_WIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_vld_i  (alloc_vld),
        .alloc_rdy_o  (alloc_rdy),
        .rel_vld_i    (rel_vld),
        .flush_req_i  (flush_req),
        .flush_done_o (flush_done),
        .free_cnt_o   (free_cnt),
        .used_cnt_o   (used_cnt),
        .full_o       (full),
        .empty_o      (empty),
        .err_o        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected values here are what the outputs show after the clock edge the row is applied on.
    typedef struct {
        logic [AW-1:0] alloc;
        logic [RW-1:0] rel;
        logic          flush;
        int            exp_free;
        logic [AW-1:0] exp_rdy;
        logic          exp_done;
        logic          exp_err;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    // Reference model state
    int   m_free;
    int   m_phase;    // 0 accepting, 1 draining, 2 completion cycle
    logic m_err;

    function automatic logic [AW-1:0] model_rdy(input int free, input int phase);
        logic [AW-1:0] r;
        r = '0;
        if (phase == 0) begin
            for (int i = 0; i < AW; i++) if (i < free) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic check_all(input string tag, input int efree, input logic [AW-1:0] erdy,
                             input logic edone, input logic eerr);
        check({tag, "_free"},  free_cnt,   efree);
        check({tag, "_used"},  used_cnt,   E - efree);
        check({tag, "_rdy"},   alloc_rdy,  erdy);
        check({tag, "_done"},  flush_done, edone);
        check({tag, "_err"},   err,        eerr);
        check({tag, "_full"},  full,       efree == 0);
        check({tag, "_empty"}, empty,      efree == E);
    endtask

    initial begin
        logic seen_done;
        logic [AW-1:0] fire;
        int nf;
        int n_mode_cycles;

        vec[0]  = '{2'b11, 4'b0000, 1'b0, 6, 2'b11, 1'b0, 1'b0};
        vec[1]  = '{2'b11, 4'b0000, 1'b0, 4, 2'b11, 1'b0, 1'b0};
        vec[2]  = '{2'b11, 4'b0000, 1'b0, 2, 2'b11, 1'b0, 1'b0};
        vec[3]  = '{2'b11, 4'b0000, 1'b0, 0, 2'b00, 1'b0, 1'b0};
        vec[4]  = '{2'b11, 4'b0001, 1'b0, 1, 2'b01, 1'b0, 1'b0};
        vec[5]  = '{2'b11, 4'b0101, 1'b0, 2, 2'b11, 1'b0, 1'b0};
        vec[6]  = '{2'b00, 4'b1111, 1'b0, 6, 2'b11, 1'b0, 1'b0};
        vec[7]  = '{2'b00, 4'b0011, 1'b0, 8, 2'b11, 1'b0, 1'b0};
        vec[8]  = '{2'b00, 4'b0001, 1'b0, 8, 2'b11, 1'b0, 1'b1};
        vec[9]  = '{2'b01, 4'b0000, 1'b0, 7, 2'b11, 1'b0, 1'b1};
        vec[10] = '{2'b11, 4'b0000, 1'b1, 5, 2'b00, 1'b0, 1'b1};
        vec[11] = '{2'b11, 4'b0001, 1'b0, 6, 2'b00, 1'b0, 1'b1};
        vec[12] = '{2'b00, 4'b0001, 1'b1, 7, 2'b00, 1'b0, 1'b1};
        vec[13] = '{2'b00, 4'b0001, 1'b0, 8, 2'b00, 1'b0, 1'b1};
        vec[14] = '{2'b00, 4'b0000, 1'b0, 8, 2'b00, 1'b1, 1'b1};
        vec[15] = '{2'b00, 4'b0000, 1'b0, 8, 2'b11, 1'b0, 1'b1};
        vec[16] = '{2'b00, 4'b0000, 1'b1, 8, 2'b00, 1'b0, 1'b1};
        vec[17] = '{2'b00, 4'b0000, 1'b0, 8, 2'b00, 1'b1, 1'b1};
        vec[18] = '{2'b00, 4'b0000, 1'b0, 8, 2'b11, 1'b0, 1'b1};

        rst = 1'b1;
        alloc_vld = '0;
        rel_vld = '0;
        flush_req = 1'b0;
        #1;
        check_all("reset", E, 2'b11, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            alloc_vld = vec[k].alloc;
            rel_vld   = vec[k].rel;
            flush_req = vec[k].flush;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", k), vec[k].exp_free, vec[k].exp_rdy,
                      vec[k].exp_done, vec[k].exp_err);
        end

        // Reset while draining with 5 entries outstanding.
        @(negedge clk);
        alloc_vld = '0; rel_vld = '0; flush_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_clears_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        alloc_vld = 2'b11;
        @(negedge clk);
        @(negedge clk);
        alloc_vld = 2'b01;
        @(negedge clk);
        alloc_vld = 2'b00;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        check_all("drain5", 3, 2'b00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("rst_mid_drain", E, 2'b11, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (flush_done === 1'b1) seen_done = 1'b1;
        end
        check("no_done_after_rst", seen_done, 1'b0);
        check_all("post_rst_idle", E, 2'b11, 1'b0, 1'b0);

        // Random traffic against the reference model.
        m_free = E;
        m_phase = 0;
        m_err = 1'b0;
        n_mode_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            alloc_vld = AW'($urandom_range(0, (1 << AW) - 1));
            rel_vld   = RW'($urandom_range(0, (1 << RW) - 1));
            if ($urandom_range(0, 31) != 0) begin
                while ($countones(rel_vld) > (E - m_free)) rel_vld = rel_vld & (rel_vld - 4'd1);
            end
            flush_req = ($urandom_range(0, 19) == 0);

            fire = alloc_vld & model_rdy(m_free, m_phase);
            nf = m_free + $countones(rel_vld) - $countones(fire);
            if (nf > E) begin
                nf = E;
                m_err = 1'b1;
            end
            case (m_phase)
                0: m_phase = flush_req ? 1 : 0;
                1: m_phase = (m_free == E) ? 2 : 1;
                default: m_phase = 0;
            endcase
            m_free = nf;
            if (m_phase != 0) n_mode_cycles++;

            @(posedge clk);
            #1;
            check_all("rand", m_free, model_rdy(m_free, m_phase), m_phase == 2, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvh_l1d_credit_tracker.md
Name: rvh_l1d_credit_tracker

Overview:
Multi-lane free-entry credit tracker for L1D buffers such as the MSHR, the store buffer and the writeback buffer.
- Each cycle it accepts up to ALLOC_WIDTH allocations and up to REL_WIDTH releases.
- Allocation and release masks are reduced with one_counter popcount instances.
- It keeps a registered free-entry count and issues per-lane allocation grants.
- A flush/drain FSM blocks new allocations until every entry has been released, then reports completion.

Parameters:
ENTRY_NUM, 8, number of tracked entries (>=2)
ALLOC_WIDTH, 2, allocation lanes per cycle (<=ENTRY_NUM)
REL_WIDTH, 4, release lanes per cycle
CNT_W (local), $clog2(ENTRY_NUM)+1, counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
alloc_vld_i  input  ALLOC_WIDTH  per-lane allocation request
alloc_rdy_o  output  ALLOC_WIDTH  per-lane grant; a lane fires when vld & rdy
rel_vld_i  input  REL_WIDTH  per-lane entry release, one entry per set bit
flush_req_i  input  1  request drain of all entries
flush_done_o  output  1  one-cycle pulse: drain complete
free_cnt_o  output  CNT_W  registered free-entry count
used_cnt_o  output  CNT_W  ENTRY_NUM - free_cnt_o
full_o  output  1  free_cnt_o == 0
empty_o  output  1  free_cnt_o == ENTRY_NUM
err_o  output  1  sticky over-release error

Behaviour:
- Reset values (async, while rst=1): free_cnt_q=ENTRY_NUM; state=IDLE; flush_done_o=0; err_o=0. This gives alloc_rdy_o = lanes [min(ALLOC_WIDTH,ENTRY_NUM)-1:0] high, full_o=0, empty_o=1 and used_cnt_o=0.
- Grant rule: alloc_rdy_o[i] = (state==IDLE) && (i < free_cnt_q).
  - Grants depend only on registered state; there is no combinational vld->rdy path.
  - Grants form a low-lane prefix.
- Fire mask: fire = alloc_vld_i & alloc_rdy_o.
  - n_alloc = popcount(fire), n_rel = popcount(rel_vld_i); both come from one_counter instances.
- Count update each cycle: free_next = free_cnt_q + n_rel - n_alloc, computed at CNT_W+1 bits.
  - Released credit becomes usable for grants only on the next cycle (1-cycle release-to-grant latency).
  - Simultaneous alloc and release in the same cycle are both applied.
- Over-release: if free_cnt_q + n_rel - n_alloc > ENTRY_NUM, then free_next saturates at ENTRY_NUM and err_o sets and stays set until rst.
  - Underflow is impossible by construction of the grant rule.
- FSM states: IDLE, DRAIN, DONE.
  - IDLE: flush_req_i=1 -> DRAIN next cycle. Allocations granted in the same cycle as flush_req_i still fire.
  - DRAIN: alloc_rdy_o=0 and releases are still counted. When free_cnt_q==ENTRY_NUM -> DONE.
  - DONE: flush_done_o=1 for exactly this cycle; alloc_rdy_o=0; -> IDLE.
  - flush_req_i is ignored in DRAIN and DONE.
- Flush latency: with the buffer already empty, a request at cycle 0 gives DRAIN at cycle 1 and the flush_done_o pulse at cycle 2. Otherwise the pulse comes 1 cycle after empty is observed in DRAIN.
- Reset mid-drain: returns to IDLE with a full credit count; no flush_done_o pulse is produced.
- Outputs free_cnt_o, used_cnt_o, full_o and empty_o are derived from registered free_cnt_q only.

Test Plan:
1. Reset, ENTRY_NUM=8, ALLOC_WIDTH=2 -> free_cnt_o=8, alloc_rdy_o=2'b11, empty_o=1, err_o=0, flush_done_o=0.
2. alloc_vld_i=2'b11 for 4 cycles, no release -> free_cnt_o counts 6,4,2,0; at 0, alloc_rdy_o=2'b00 and full_o=1.
3. free=1, alloc_vld_i=2'b11 -> only lane 0 fires (alloc_rdy_o=2'b01); next free=0. Simultaneously rel_vld_i=4'b0101 -> next free=1+2-1=2.
4. free=8, rel_vld_i=4'b0001 -> free stays 8, err_o=1 next cycle and remains 1 after further clean traffic.
5. used=3, flush_req_i pulse -> alloc_rdy_o=0 from the next cycle; release 3 entries over 3 cycles -> free=8, flush_done_o high one cycle later for exactly 1 cycle, then alloc_rdy_o=2'b11.
6. Assert rst during DRAIN with used=5 -> immediately free_cnt_o=8 and IDLE; after release, no flush_done_o pulse ever appears.
